// File: rtl/alu_req_arbiter_if.sv
// Request/response bundle for the shared-ALU arbiter.
// rsp_overflow exists only when ALU_ARB_OVF_EN is defined.
interface alu_req_arbiter_if #(
  parameter int WIDTH = 8
);
  logic             req0_valid;
  logic             req0_ready;
  logic [WIDTH-1:0] req0_a;
  logic [WIDTH-1:0] req0_b;
  logic [2:0]       req0_op;
  logic             req1_valid;
  logic             req1_ready;
  logic [WIDTH-1:0] req1_a;
  logic [WIDTH-1:0] req1_b;
  logic [2:0]       req1_op;
  logic             rsp_valid;
  logic             rsp_ready;
  logic             rsp_id;
  logic [WIDTH-1:0] rsp_result;
  logic             rsp_zero;
  logic             rsp_carry;
  logic             rsp_negative;
`ifdef ALU_ARB_OVF_EN
  logic             rsp_overflow;
`endif

  modport master (
    output req0_valid, req0_a, req0_b, req0_op,
    output req1_valid, req1_a, req1_b, req1_op,
    output rsp_ready,
    input  req0_ready, req1_ready,
    input  rsp_valid, rsp_id, rsp_result,
`ifdef ALU_ARB_OVF_EN
    input  rsp_overflow,
`endif
    input  rsp_zero, rsp_carry, rsp_negative
  );

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_op,
    input  req1_valid, req1_a, req1_b, req1_op,
    input  rsp_ready,
    output req0_ready, req1_ready,
    output rsp_valid, rsp_id, rsp_result,
`ifdef ALU_ARB_OVF_EN
    output rsp_overflow,
`endif
    output rsp_zero, rsp_carry, rsp_negative
  );
endinterface

// File: rtl/alu_req_arbiter.sv
// Round-robin arbiter sharing one flag-producing ALU between two requesters.
// Define ALU_ARB_OVF_EN to add the registered signed-overflow flag.
module alu_req_arbiter #(
  parameter int WIDTH = 8
) (
  input logic              clk,
  input logic              rst_n,
  alu_req_arbiter_if.slave bus
);
  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RESP = 1'b1;
  localparam int MSB = WIDTH - 1;

  logic [0:0]       r_state;
  logic             r_last;
  logic             r_id;
  logic [WIDTH-1:0] r_result;
  logic             r_zero;
  logic             r_carry;
  logic             r_neg;
`ifdef ALU_ARB_OVF_EN
  logic             r_ovf;
  logic             w_ovf;
`endif

  logic             w_idle;
  logic             w_gnt0;
  logic             w_gnt1;
  logic             w_acc;
  logic [WIDTH-1:0] w_a;
  logic [WIDTH-1:0] w_b;
  logic [2:0]       w_op;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_dif;
  logic [WIDTH-1:0] w_res;
  logic             w_cy;

  // r_last names the previous winner; a tie goes to the other one
  assign w_idle = (r_state == S_IDLE) && rst_n;
  assign w_gnt0 = w_idle && bus.req0_valid
               && (!bus.req1_valid || r_last);
  assign w_gnt1 = w_idle && bus.req1_valid
               && (!bus.req0_valid || !r_last);
  assign w_acc  = w_gnt0 || w_gnt1;

  assign bus.req0_ready = w_gnt0;
  assign bus.req1_ready = w_gnt1;

  assign w_a  = w_gnt1 ? bus.req1_a  : bus.req0_a;
  assign w_b  = w_gnt1 ? bus.req1_b  : bus.req0_b;
  assign w_op = w_gnt1 ? bus.req1_op : bus.req0_op;

  // borrow of the widened difference is exactly a < b
  assign w_sum = {1'b0, w_a} + {1'b0, w_b};
  assign w_dif = {1'b0, w_a} - {1'b0, w_b};

  // ALU result and carry for the selected operands
  always_comb begin
    w_res = '0;
    w_cy  = 1'b0;
    case (w_op)
      3'b000: begin
        w_res = w_sum[WIDTH-1:0];
        w_cy  = w_sum[WIDTH];
      end
      3'b001: begin
        w_res = w_dif[WIDTH-1:0];
        w_cy  = w_dif[WIDTH];
      end
      3'b010: w_res = w_a & w_b;
      3'b011: w_res = w_a | w_b;
      3'b100: w_res = w_a ^ w_b;
      3'b101: w_res = ~w_a;
      3'b110: w_res = {w_a[WIDTH-2:0], 1'b0};
      default: w_res = {1'b0, w_a[WIDTH-1:1]};
    endcase
  end

`ifdef ALU_ARB_OVF_EN
  // signed overflow for add/sub only
  always_comb begin
    w_ovf = 1'b0;
    unique case (1'b1)
      (w_op == 3'b000):
        w_ovf = (w_a[MSB] == w_b[MSB])
             && (w_res[MSB] != w_a[MSB]);
      (w_op == 3'b001):
        w_ovf = (w_a[MSB] != w_b[MSB])
             && (w_res[MSB] != w_a[MSB]);
      default: w_ovf = 1'b0;
    endcase
  end
`endif

  // FSM plus response register: capture on accept, hold until taken
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_last   <= 1'b1;
      r_id     <= 1'b0;
      r_result <= '0;
      r_zero   <= 1'b0;
      r_carry  <= 1'b0;
      r_neg    <= 1'b0;
`ifdef ALU_ARB_OVF_EN
      r_ovf    <= 1'b0;
`endif
    end else if (r_state == S_IDLE) begin
      if (w_acc) begin
        r_state  <= S_RESP;
        r_last   <= w_gnt1;
        r_id     <= w_gnt1;
        r_result <= w_res;
        r_zero   <= (w_res == '0);
        r_carry  <= w_cy;
        r_neg    <= w_res[MSB];
`ifdef ALU_ARB_OVF_EN
        r_ovf    <= w_ovf;
`endif
      end
    end else if (bus.rsp_ready) begin
      r_state <= S_IDLE;
    end
  end

  assign bus.rsp_valid    = (r_state == S_RESP);
  assign bus.rsp_id       = r_id;
  assign bus.rsp_result   = r_result;
  assign bus.rsp_zero     = r_zero;
  assign bus.rsp_carry    = r_carry;
  assign bus.rsp_negative = r_neg;
`ifdef ALU_ARB_OVF_EN
  assign bus.rsp_overflow = r_ovf;
`endif
endmodule
